// File: rtl/sort_out_fifo.sv
// Output FIFO for sorted words: first-word fall-through, sticky overflow flag,
// occupancy counter kept separately from the pointers so full/empty never alias.

module sort_out_fifo_entry #(
    parameter int data_width = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [data_width-1:0] d,
    output logic [data_width-1:0] q
);
    logic [data_width-1:0] q_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q_q <= '0;
        else if (we) q_q <= d;
    end

    assign q = q_q;
endmodule

module sort_out_fifo #(
    parameter int data_width = 8,
    parameter int depth      = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       sort_val,
    input  logic [data_width-1:0]      sort,
    output logic                       sort_rdy,
    output logic [data_width-1:0]      sort_data,
    output logic                       data_val,
    input  logic                       data_rdy,
    output logic [$clog2(depth):0]     level,
    output logic                       ovf
);
    localparam int AW = $clog2(depth);
    localparam int LW = AW + 1;

    logic [AW-1:0]                      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0]                      level_q, level_d;
    logic                               ovf_q, ovf_d;
    logic                               wr_en, rd_en;
    logic [depth-1:0]                   ent_we;
    logic [depth-1:0][data_width-1:0]   ent_q;

    // Handshake flags depend on registered occupancy only.
    assign sort_rdy  = (level_q < LW'(depth));
    assign data_val  = (level_q != '0);
    assign sort_data = data_val ? ent_q[rptr_q] : '0;
    assign level     = level_q;
    assign ovf       = ovf_q;

    assign wr_en = sort_val & sort_rdy & ~clr;
    assign rd_en = data_val & data_rdy & ~clr;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        if (clr) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
            ovf_d   = 1'b0;
        end else begin
            if (wr_en) wptr_d = wptr_q + AW'(1);
            if (rd_en) rptr_d = rptr_q + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
            // A read in the same cycle does not make room for a word offered while full.
            if (sort_val && !sort_rdy) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
        end
    end

    for (genvar g = 0; g < depth; g++) begin : g_ent
        assign ent_we[g] = wr_en && (wptr_q == AW'(g));
        sort_out_fifo_entry #(.data_width(data_width)) u_ent (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (ent_we[g]),
            .d     (sort),
            .q     (ent_q[g])
        );
    end
endmodule

// File: tb/tb_sort_out_fifo.sv
// Scoreboard bench for sort_out_fifo (data_width=8, depth=4).

module tb_sort_out_fifo;
    localparam int DW = 8;
    localparam int DP = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          sort_val = 1'b0;
    logic [DW-1:0] sort = '0;
    logic          sort_rdy;
    logic [DW-1:0] sort_data;
    logic          data_val;
    logic          data_rdy = 1'b0;
    logic [2:0]    level;
    logic          ovf;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] sb[$];
    logic          ovf_m = 1'b0;

    always #5 clk = ~clk;

    sort_out_fifo #(.data_width(DW), .depth(DP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .sort_val  (sort_val),
        .sort      (sort),
        .sort_rdy  (sort_rdy),
        .sort_data (sort_data),
        .data_val  (data_val),
        .data_rdy  (data_rdy),
        .level     (level),
        .ovf       (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".level"}, 32'(level), 32'(sb.size()));
        chk({tag, ".dval"},  32'(data_val), 32'(sb.size() > 0));
        chk({tag, ".srdy"},  32'(sort_rdy), 32'(sb.size() < DP));
        chk({tag, ".ovf"},   32'(ovf), 32'(ovf_m));
        chk({tag, ".data"},  32'(sort_data), (sb.size() > 0) ? 32'(sb[0]) : 32'h0);
    endtask

    // One clock: drive inputs, check outputs before the edge, advance model with the edge.
    task automatic step(input string tag, input logic sv, input logic [DW-1:0] s,
                        input logic dr, input logic c);
        bit rd, wr;
        sort_val = sv; sort = s; data_rdy = dr; clr = c;
        #1;
        chk_state(tag);
        rd = (sb.size() > 0) && dr && !c;
        wr = sv && (sb.size() < DP) && !c;
        @(posedge clk);
        if (c) begin
            sb.delete();
            ovf_m = 1'b0;
        end else begin
            if (sv && sb.size() == DP) ovf_m = 1'b1;
            if (rd) void'(sb.pop_front());
            if (wr) sb.push_back(s);
        end
        #1;
        sort_val = 1'b0; data_rdy = 1'b0; clr = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst.level", 32'(level), 0);
        chk("rst.dval",  32'(data_val), 0);
        chk("rst.srdy",  32'(sort_rdy), 1);
        chk("rst.data",  32'(sort_data), 0);
        chk("rst.ovf",   32'(ovf), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Three writes with no reads.
        step("w1", 1, 8'h11, 0, 0);
        step("w2", 1, 8'h22, 0, 0);
        step("w3", 1, 8'h33, 0, 0);
        chk("r30.level", 32'(level), 3);
        chk("r30.data",  32'(sort_data), 32'h11);
        chk("r30.srdy",  32'(sort_rdy), 1);

        // Fill, then offer a word while full together with a read.
        step("w4", 1, 8'h44, 0, 0);
        chk("r31.full", 32'(sort_rdy), 0);
        step("ovf", 1, 8'h55, 1, 0);
        chk("r31.ovf", 32'(ovf), 1);
        chk("r31.level", 32'(level), 3);
        for (int i = 0; i < 4; i++) step("drain31", 0, 8'h00, 1, 0);
        chk("r31.empty", 32'(data_val), 0);
        chk("r31.sticky", 32'(ovf), 1);
        step("clr1", 0, 8'h00, 0, 1);

        // Simultaneous read/write at level 2 across pointer wrap.
        step("p1", 1, 8'h9E, 0, 0);
        step("p2", 1, 8'h9F, 0, 0);
        for (int i = 0; i < 6; i++) step("rw", 1, 8'hA0 + 8'(i), 1, 0);
        chk("r32.level", 32'(level), 2);
        chk("r32.head",  32'(sort_data), 32'hA4);
        for (int i = 0; i < 2; i++) step("drain32", 0, 8'h00, 1, 0);

        // Fall-through latency into an empty FIFO.
        step("ft.w", 1, 8'h7E, 1, 0);
        chk("r33.dval", 32'(data_val), 1);
        chk("r33.data", 32'(sort_data), 32'h7E);
        step("ft.r", 0, 8'h00, 1, 0);
        chk("r33.level", 32'(level), 0);
        chk("r33.data0", 32'(sort_data), 0);

        // Clear wins over a concurrent write.
        for (int i = 0; i < 5; i++) step("f34", 1, 8'hC0 + 8'(i), 0, 0);
        step("pop34", 0, 8'h00, 1, 0);
        chk("r34.pre", 32'(ovf), 1);
        step("clr34", 1, 8'hEE, 0, 1);
        chk("r34.level", 32'(level), 0);
        chk("r34.ovf",   32'(ovf), 0);
        chk("r34.dval",  32'(data_val), 0);
        chk("r34.data",  32'(sort_data), 0);
        step("idle34", 0, 8'h00, 0, 0);

        // Asynchronous reset pulse between edges.
        for (int i = 0; i < 3; i++) step("f35", 1, 8'h30 + 8'(i), 0, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("r35.level", 32'(level), 0);
        chk("r35.dval",  32'(data_val), 0);
        chk("r35.srdy",  32'(sort_rdy), 1);
        chk("r35.data",  32'(sort_data), 0);
        rst_n = 1'b1;
        sb.delete();
        ovf_m = 1'b0;
        step("w35", 1, 8'h5A, 0, 0);
        chk("r35.first", 32'(sort_data), 32'h5A);
        step("r35", 0, 8'h00, 1, 0);

        // Random traffic against the scoreboard.
        for (int i = 0; i < 200; i++)
            step("rnd", 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 40) == 0));
        while (sb.size() > 0 && total < 100000) step("final", 0, 8'h00, 1, 0);
        chk("final.empty", 32'(data_val), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
